// File: rtl/video_rx_pkg.sv
// video_rx_pkg: shared state encoding, default geometry and RGB565 field widths
package video_rx_pkg;
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} rx_state_t;
  localparam int H_RES_DEF = 480;
  localparam int V_RES_DEF = 272;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers a sync/de input, normalises polarity to active-high and flags its edges
module sync_edge_det #(
  parameter bit ACT_LOW = 1'b0
) (
  input  logic clk_pix,
  input  logic rst_pix_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic q_d;
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= din ^ ACT_LOW;
      q_d <= q;
    end
  end
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/video_rx_272p.sv
// video_rx_272p: RGB565 parallel video receiver with coordinate recovery and geometry lock
module video_rx_272p
  import video_rx_pkg::*;
#(
  parameter int CORDW        = 10,
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF,
  parameter int LOCK_FRAMES  = 2,
  parameter bit SYNC_ACT_LOW = 1'b1
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             vid_hsync,
  input  logic             vid_vsync,
  input  logic             vid_de,
  input  logic [R_W-1:0]   vid_r,
  input  logic [G_W-1:0]   vid_g,
  input  logic [B_W-1:0]   vid_b,
  output logic             pix_valid,
  output logic [CORDW-1:0] pix_x,
  output logic [CORDW-1:0] pix_y,
  output logic [R_W-1:0]   pix_r,
  output logic [G_W-1:0]   pix_g,
  output logic [B_W-1:0]   pix_b,
  output logic             frame_start,
  output logic             line_start,
  output logic             locked,
  output logic             err_line,
  output logic             err_frame
);
  localparam logic [CORDW-1:0] C_MAX  = '1;
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_RES - 1);
  localparam logic [CORDW:0]   V_CNT  = (CORDW + 1)'(V_RES);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);
  rx_state_t state, state_nx;
  logic [3:0] gcnt, gcnt_nx;
  logic de1, de_rise, de_fall, vs_edge, vs_lvl_unused, vs_fall_unused, hs_unused;
  logic [R_W-1:0] r1;
  logic [G_W-1:0] g1;
  logic [B_W-1:0] b1;
  logic [CORDW-1:0] x_cnt, y_cnt, cur_x, cur_y;
  logic [CORDW:0] lines;
  logic err_seen, err_line_c, err_frame_c, any_err, valid_c, lock_c;

  sync_edge_det #(.ACT_LOW(SYNC_ACT_LOW)) u_vs (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .din(vid_vsync),
    .q(vs_lvl_unused), .rise(vs_edge), .fall(vs_fall_unused)
  );
  sync_edge_det #(.ACT_LOW(1'b0)) u_de (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .din(vid_de),
    .q(de1), .rise(de_rise), .fall(de_fall)
  );

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      hs_unused <= 1'b0;
      r1        <= '0;
      g1        <= '0;
      b1        <= '0;
    end else begin
      hs_unused <= vid_hsync ^ SYNC_ACT_LOW;
      r1        <= vid_r;
      g1        <= vid_g;
      b1        <= vid_b;
    end
  end

  assign cur_x       = de_rise ? '0 : (x_cnt == C_MAX ? C_MAX : x_cnt + CORDW'(1));
  assign cur_y       = vs_edge ? '0 : y_cnt;
  assign lines       = {1'b0, y_cnt} + {{CORDW{1'b0}}, de_fall};
  assign err_line_c  = de_fall && x_cnt != H_LAST;
  assign err_frame_c = vs_edge && state != SEARCH && lines != V_CNT;
  assign any_err     = err_line_c || err_frame_c;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      err_seen <= 1'b0;
    end else begin
      if (de1) x_cnt <= cur_x;
      y_cnt    <= vs_edge ? '0 : (de_fall && y_cnt != C_MAX) ? y_cnt + CORDW'(1) : y_cnt;
      err_seen <= !vs_edge && (err_seen || any_err);
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state <= SEARCH;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      gcnt  <= gcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gcnt_nx  = gcnt;
    unique case (state)
      SEARCH:
        if (vs_edge) begin
          state_nx = ACQUIRE;
          gcnt_nx  = '0;
        end
      ACQUIRE:
        if (any_err) gcnt_nx = '0;
        else if (vs_edge && !err_seen) begin
          gcnt_nx  = gcnt + 4'd1;
          state_nx = (gcnt + 4'd1 == LOCK_N) ? LOCKED : ACQUIRE;
        end
      LOCKED:
        if (any_err) begin
          state_nx = ACQUIRE;
          gcnt_nx  = '0;
        end
      default: state_nx = SEARCH;
    endcase
  end

  always_comb begin
    lock_c  = state == LOCKED;
    valid_c = de1 && lock_c;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      locked      <= 1'b0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      pix_valid   <= valid_c;
      pix_x       <= cur_x;
      pix_y       <= cur_y;
      pix_r       <= valid_c ? r1 : '0;
      pix_g       <= valid_c ? g1 : '0;
      pix_b       <= valid_c ? b1 : '0;
      frame_start <= valid_c && cur_x == '0 && cur_y == '0;
      line_start  <= valid_c && cur_x == '0;
      locked      <= lock_c;
      err_line    <= err_line_c;
      err_frame   <= err_frame_c;
    end
  end
endmodule

// File: tb/tb_video_rx_272p.sv
// tb_video_rx_272p: randomized directed bench comparing video_rx_272p against a frame-level reference model
module tb_video_rx_272p;
  localparam int CORDW = 5, H_RES = 16, V_RES = 10, LOCK_FRAMES = 2;
  localparam int MAXC = (1 << CORDW) - 1;
  localparam int SRCH = 0, ACQ = 1, LCK = 2;
  typedef struct packed {
    logic v;
    logic [CORDW-1:0] x, y;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic fs, ls, lk, el, ef;
  } out_t;
  logic clk_pix = 1'b0, rst_pix_n = 1'b0;
  logic vid_hsync = 1'b1, vid_vsync = 1'b1, vid_de = 1'b0;
  logic [4:0] vid_r = '0, vid_b = '0;
  logic [5:0] vid_g = '0;
  logic pix_valid, frame_start, line_start, locked, err_line, err_frame;
  logic [CORDW-1:0] pix_x, pix_y;
  logic [4:0] pix_r, pix_b;
  logic [5:0] pix_g;
  int n_checks = 0, n_errors = 0;
  int n_el = 0, n_ef = 0, n_valid = 0, max_x = 0, max_y = 0;
  int mode = SRCH, good = 0, run = 0, lines = 0;
  bit dirty = 0, prev_vs = 0, have_prev = 0;
  out_t pend = '0;

  always #5 clk_pix = ~clk_pix;

  video_rx_272p #(
    .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .LOCK_FRAMES(LOCK_FRAMES), .SYNC_ACT_LOW(1'b1)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .line_start(line_start), .locked(locked),
    .err_line(err_line), .err_frame(err_frame)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic out_t sample_all();
    return {pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, line_start, locked, err_line, err_frame};
  endfunction

  task automatic model_reset();
    mode = SRCH; good = 0; run = 0; lines = 0; dirty = 0; prev_vs = 0; have_prev = 0;
  endtask

  task automatic beat(bit de, bit vs);
    out_t e, o;
    bit bnd, el, ef;
    int gx, gy;
    vid_de = de;
    vid_vsync = ~vs;
    vid_hsync = 1'($urandom);
    vid_r = 5'($urandom);
    vid_g = 6'($urandom);
    vid_b = 5'($urandom);
    el = 0; ef = 0; gx = 0;
    bnd = vs && !prev_vs;
    prev_vs = vs;
    if (!de && run > 0) begin
      el = run != H_RES;
      lines++;
      run = 0;
    end
    if (bnd) begin
      ef = mode != SRCH && lines != V_RES;
      lines = 0;
    end
    if (de) begin
      run++;
      gx = run - 1 > MAXC ? MAXC : run - 1;
    end
    gy = lines > MAXC ? MAXC : lines;
    e = '0;
    e.v = de && mode == LCK;
    if (e.v) begin
      e.x = CORDW'(gx);
      e.y = CORDW'(gy);
      e.r = vid_r;
      e.g = vid_g;
      e.b = vid_b;
    end
    e.fs = e.v && gx == 0 && gy == 0;
    e.ls = e.v && gx == 0;
    e.lk = mode == LCK;
    e.el = el;
    e.ef = ef;
    if (mode == SRCH) begin
      if (bnd) begin mode = ACQ; good = 0; end
    end else if (el || ef) begin
      mode = ACQ; good = 0;
    end else if (bnd && !dirty) begin
      good++;
      if (good == LOCK_FRAMES) mode = LCK;
    end
    dirty = bnd ? 1'b0 : (dirty || el || ef);
    @(posedge clk_pix);
    @(negedge clk_pix);
    if (have_prev) begin
      o = sample_all();
      if (!pend.v) begin o.x = '0; o.y = '0; end
      if (pix_valid) begin
        n_valid++;
        if (int'(pix_x) > max_x) max_x = int'(pix_x);
        if (int'(pix_y) > max_y) max_y = int'(pix_y);
      end
      n_el += int'(err_line);
      n_ef += int'(err_frame);
      check("beat", o, pend);
    end
    pend = e;
    have_prev = 1;
  endtask

  task automatic line(int len, int tail);
    repeat (len) beat(1, 0);
    repeat (tail) beat(0, 0);
  endtask

  task automatic frame(int nl = V_RES, int drop_l = -1, int long_l = -1, bit coinc = 0, int stop_l = -1);
    repeat (2) beat(0, 1);
    repeat (3) beat(0, 0);
    for (int l = 0; l < nl; l++) begin
      int tail;
      tail = (coinc && l == nl - 1) ? 0 : int'($urandom_range(6, 2));
      if (l == stop_l) begin
        line(H_RES / 2, 0);
        return;
      end
      if (l == drop_l) begin
        line(6, 1);
        line(H_RES - 7, tail);
      end else line(l == long_l ? 40 : H_RES, tail);
    end
  endtask

  initial begin
    int e0, f0, v0;
    repeat (2) @(posedge clk_pix);
    @(negedge clk_pix);
    check("reset_outputs", sample_all(), '0);
    rst_pix_n = 1'b1;
    repeat (4) beat(0, 0);
    repeat (3) frame();
    check("locked_after_3rd_vsync", 32'(locked), 32'd1);
    check("no_errors_clean_lock", n_el + n_ef, 0);
    v0 = n_valid; max_x = 0; max_y = 0;
    frame();
    check("valid_pixels_per_frame", n_valid - v0, H_RES * V_RES);
    check("max_x", max_x, H_RES - 1);
    check("max_y", max_y, V_RES - 1);
    e0 = n_el;
    frame(.drop_l(3));
    check("short_line_err_count", n_el - e0, 2);
    check("short_line_unlock", 32'(locked), 32'd0);
    repeat (3) frame();
    check("short_line_relock", 32'(locked), 32'd1);
    f0 = n_ef;
    frame(.nl(V_RES + 1));
    check("extra_line_still_locked", 32'(locked), 32'd1);
    frame();
    check("extra_line_err_frame", n_ef - f0, 1);
    check("extra_line_unlock", 32'(locked), 32'd0);
    repeat (2) frame();
    check("extra_line_relock", 32'(locked), 32'd1);
    e0 = n_el; max_x = 0;
    frame(.long_l(2));
    check("long_line_x_saturates", max_x, MAXC);
    check("long_line_err", n_el - e0, 1);
    repeat (3) frame();
    check("long_line_relock", 32'(locked), 32'd1);
    e0 = n_el; f0 = n_ef;
    frame(.coinc(1));
    frame();
    check("coincident_no_errors", (n_el - e0) + (n_ef - f0), 0);
    check("coincident_lock_kept", 32'(locked), 32'd1);
    frame(.stop_l(5));
    check("pre_reset_valid", 32'(pix_valid), 32'd1);
    rst_pix_n = 1'b0;
    #1;
    check("async_reset_outputs", sample_all(), '0);
    vid_de = 1'b0;
    vid_vsync = 1'b1;
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    model_reset();
    v0 = n_valid;
    repeat (4) beat(0, 0);
    repeat (2) frame();
    check("no_valid_before_relock", n_valid - v0, 0);
    frame();
    check("reset_relock", 32'(locked), 32'd1);
    check("reset_relock_pixels", n_valid - v0, H_RES * V_RES);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
